// File: rtl/data_sram_responder_if.sv
// Split address/data handshake between an EX-stage requester and the data RAM responder.
interface data_sram_responder_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (output req, wr, size, wstrb, addr, wdata,
                    input  addr_ok, data_ok, rdata);
    modport slave  (input  req, wr, size, wstrb, addr, wdata,
                    output addr_ok, data_ok, rdata);
endinterface

// File: rtl/data_sram_responder.sv
// Word-addressed data RAM responder: bounded in-order request queue, fixed LAT response latency.
// Define DSRAM_RAND_DELAY_EN to add LFSR-driven random accept gating and response stalls.
module data_sram_responder #(
    parameter int AW    = 12,
    parameter int LAT   = 2,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    data_sram_responder_if.slave bus,
    output logic [2:0]           outstanding
);
    localparam int         PW   = $clog2(DEPTH);
    localparam logic [2:0] LAT3 = 3'(LAT);

    logic [31:0]            mem [2**AW];
    logic [DEPTH-1:0]       ent_vld, ent_wr;
    logic [DEPTH-1:0][31:0] ent_data;
    logic [DEPTH-1:0][2:0]  ent_age;
    logic [PW-1:0]          head, tail;
    logic [3:0]             cnt;
    logic                   data_ok_q;
    logic [31:0]            rdata_q;

    logic [AW-1:0]          idx;
    logic [31:0]            rd_word;
    logic                   accept, pop, gate, stall_n;
    logic [PW-1:0]          head_n;
    logic [DEPTH-1:0]       vld_n;
    logic [DEPTH-1:0][2:0]  age_n;
    logic                   data_ok_n;
    logic [31:0]            rdata_n, head_word;

`ifdef DSRAM_RAND_DELAY_EN
    logic [15:0] lfsr, lfsr_n;
    assign lfsr_n  = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    assign gate    = ~lfsr[0];
    // data_ok is registered, so the stall decision uses the LFSR value of the response cycle
    assign stall_n = lfsr_n[1];
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) lfsr <= 16'hACE1;
        else         lfsr <= lfsr_n;
`else
    assign gate    = 1'b1;
    assign stall_n = 1'b0;
`endif

    assign bus.addr_ok = resetn & (cnt < 4'(DEPTH)) & gate;
    assign accept      = bus.req & bus.addr_ok;
    assign pop         = data_ok_q;
    assign idx         = bus.addr[AW+1:2];
    assign rd_word     = mem[idx];
    assign bus.data_ok = data_ok_q;
    assign bus.rdata   = rdata_q;
    // cnt can reach 8 only when DEPTH=8; the 3-bit port saturates there
    assign outstanding = cnt[3] ? 3'd7 : cnt[2:0];

    // Next-state queue view, so data_ok/rdata can be registered for the cycle they are due
    always_comb begin
        head_n = head + PW'(pop);
        for (int i = 0; i < DEPTH; i++) begin
            vld_n[i] = ent_vld[i];
            age_n[i] = 3'd0;
            if (pop && head == PW'(i)) vld_n[i] = 1'b0;
            if (accept && tail == PW'(i)) begin
                vld_n[i] = 1'b1;
                age_n[i] = 3'd1;
            end else if (vld_n[i]) begin
                age_n[i] = (ent_age[i] == LAT3) ? LAT3 : ent_age[i] + 3'd1;
            end
        end
        if (accept && tail == head_n) head_word = bus.wr ? 32'h0 : rd_word;
        else                          head_word = ent_wr[head_n] ? 32'h0 : ent_data[head_n];
        data_ok_n = vld_n[head_n] && (age_n[head_n] == LAT3) && !stall_n;
        rdata_n   = data_ok_n ? head_word : 32'h0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ent_vld   <= '0;
            ent_wr    <= '0;
            ent_data  <= '0;
            ent_age   <= '0;
            head      <= '0;
            tail      <= '0;
            cnt       <= '0;
            data_ok_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            ent_vld   <= vld_n;
            ent_age   <= age_n;
            head      <= head_n;
            if (accept) begin
                ent_wr[tail]   <= bus.wr;
                ent_data[tail] <= bus.wr ? 32'h0 : rd_word;
                tail           <= tail + PW'(1);
            end
            cnt       <= cnt + 4'(accept) - 4'(pop);
            data_ok_q <= data_ok_n;
            rdata_q   <= rdata_n;
        end
    end

    // Array itself is never reset; addr_ok already blocks writes while resetn is low
    always_ff @(posedge clk)
        if (accept && bus.wr)
            for (int b = 0; b < 4; b++)
                if (bus.wstrb[b]) mem[idx][8*b +: 8] <= bus.wdata[8*b +: 8];
endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: a LAT=2 instance and a LAT=6 instance (to fill the queue) share one request stream.
module tb_data_sram_responder;
  localparam int AW = 12, DEPTH = 4, L0 = 2, L1 = 6;

  logic       clk = 1'b0;
  logic       resetn;
  logic [2:0] outst0, outst1;
  data_sram_responder_if bus0();
  data_sram_responder_if bus1();

  data_sram_responder #(.AW(AW), .LAT(L0), .DEPTH(DEPTH)) dut0 (
    .clk(clk), .resetn(resetn), .bus(bus0.slave), .outstanding(outst0));
  data_sram_responder #(.AW(AW), .LAT(L1), .DEPTH(DEPTH)) dut1 (
    .clk(clk), .resetn(resetn), .bus(bus1.slave), .outstanding(outst1));

  assign bus1.req   = bus0.req;
  assign bus1.wr    = bus0.wr;
  assign bus1.size  = bus0.size;
  assign bus1.wstrb = bus0.wstrb;
  assign bus1.addr  = bus0.addr;
  assign bus1.wdata = bus0.wdata;

  logic        dok [2];
  logic        aok [2];
  logic [31:0] rd  [2];
  logic [2:0]  ost [2];
  assign dok[0] = bus0.data_ok;  assign dok[1] = bus1.data_ok;
  assign aok[0] = bus0.addr_ok;  assign aok[1] = bus1.addr_ok;
  assign rd[0]  = bus0.rdata;    assign rd[1]  = bus1.rdata;
  assign ost[0] = outst0;        assign ost[1] = outst1;

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: per instance, a queue of {due cycle, expected rdata} plus a word memory
  typedef struct { int due; logic [31:0] data; } exp_t;
  exp_t        q [2][$];
  logic [31:0] mm [int];
  int          checks = 0, errors = 0;
  int          pulses [2] = '{0, 0};
  int          accepts [2] = '{0, 0};
  logic [31:0] last_rdata [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_cycle();
    for (int u = 0; u < 2; u++) begin
      int n, k, lat;
      logic hit;
      logic [31:0] wv;
      lat = (u == 0) ? L0 : L1;
      n = q[u].size();
      chk($sformatf("outstanding%0d", u), 32'(ost[u]), 32'(n));
`ifdef DSRAM_RAND_DELAY_EN
      chk($sformatf("addr_ok_full%0d", u), 32'(aok[u] && n >= DEPTH), 32'd0);
      hit = dok[u] && n > 0;
      if (dok[u]) chk($sformatf("data_ok_pending%0d", u), 32'(hit), 32'd1);
      if (hit) chk($sformatf("data_ok_early%0d", u), 32'(cyc >= q[u][0].due), 32'd1);
`else
      chk($sformatf("addr_ok%0d", u), 32'(aok[u]), 32'(n < DEPTH));
      hit = n > 0 && q[u][0].due == cyc;
      chk($sformatf("data_ok%0d", u), 32'(dok[u]), 32'(hit));
`endif
      if (hit) begin
        if (!$isunknown(q[u][0].data)) chk($sformatf("rdata%0d", u), rd[u], q[u][0].data);
        last_rdata[u] = rd[u];
        pulses[u]++;
        void'(q[u].pop_front());
      end
      if (bus0.req && aok[u]) begin
        accepts[u]++;
        k = u * (1 << AW) + int'(bus0.addr[AW+1:2]);
        wv = mm.exists(k) ? mm[k] : 32'hxxxx_xxxx;
        if (bus0.wr) begin
          for (int b = 0; b < 4; b++)
            if (bus0.wstrb[b]) wv[8*b +: 8] = bus0.wdata[8*b +: 8];
          mm[k] = wv;
          q[u].push_back('{cyc + lat, 32'h0});
        end else begin
          q[u].push_back('{cyc + lat, wv});
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic w, input logic [3:0] st,
                      input logic [31:0] a, input logic [31:0] d);
    bus0.req = r; bus0.wr = w; bus0.wstrb = st; bus0.addr = a; bus0.wdata = d;
    bus0.size = 2'd2;
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1 bus0.req = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic drain();
    for (int i = 0; i < 3000 && (q[0].size() > 0 || q[1].size() > 0); i++) idle(1);
    chk("drain0", 32'(q[0].size()), 32'd0);
    chk("drain1", 32'(q[1].size()), 32'd0);
  endtask

  initial begin
    int acc0, p0, nst;
    logic [31:0] a;
    bus0.req = 1'b0; bus0.wr = 1'b0; bus0.size = 2'd2; bus0.wstrb = 4'h0;
    bus0.addr = 32'h0; bus0.wdata = 32'h0;
    resetn = 1'b1;
    #1 resetn = 1'b0;
    #1;
    chk("rst_data_ok", 32'(bus0.data_ok), 32'd0);
    chk("rst_addr_ok", 32'(bus0.addr_ok), 32'd0);
    chk("rst_outstanding", 32'(outst0), 32'd0);
    chk("rst_rdata", bus0.rdata, 32'h0);
    @(posedge clk); @(posedge clk);
    #3 resetn = 1'b1;
    @(posedge clk); #1;

    // Store then load the same word on consecutive cycles
    step(1'b1, 1'b1, 4'hF, 32'h1C00_0010, 32'h1234_5678);
    step(1'b1, 1'b0, 4'h0, 32'h1C00_0010, 32'h0);
    idle(3);
`ifndef DSRAM_RAND_DELAY_EN
    chk("t1_load", last_rdata[0], 32'h1234_5678);
`endif
    // Single-byte store into lane 2
    step(1'b1, 1'b1, 4'b0100, 32'h1C00_0012, 32'hAAAA_AAAA);
    step(1'b1, 1'b0, 4'h0, 32'h1C00_0010, 32'h0);
    idle(3);
`ifndef DSRAM_RAND_DELAY_EN
    chk("t2_byte", last_rdata[0], 32'h12AA_5678);
`endif
    // Aliasing modulo 2^(AW+2)
    step(1'b1, 1'b1, 4'hF, 32'h0000_4008, 32'hCAFE_F00D);
    step(1'b1, 1'b0, 4'h0, 32'h0000_0008, 32'h0);
    idle(3);
`ifndef DSRAM_RAND_DELAY_EN
    chk("t5_alias", last_rdata[0], 32'hCAFE_F00D);
`endif
    drain();

    // req held high until the LAT=6 instance has accepted 6 loads (queue fills)
    acc0 = accepts[1]; p0 = pulses[1]; nst = 0;
    while (accepts[1] - acc0 < 6 && nst < 100) begin
      step(1'b1, 1'b0, 4'h0, 32'h1C00_0010, 32'h0);
      nst++;
    end
`ifndef DSRAM_RAND_DELAY_EN
    chk("t3_steps", 32'(nst), 32'd9);
`endif
    drain();
    chk("t3_pulses", 32'(pulses[1] - p0), 32'd6);
    chk("t3_outst", 32'(outst1), 32'd0);

    // Reset pulse with three loads in flight
    step(1'b1, 1'b0, 4'h0, 32'h1C00_0010, 32'h0);
    step(1'b1, 1'b0, 4'h0, 32'h0000_0008, 32'h0);
    step(1'b1, 1'b0, 4'h0, 32'h1C00_0010, 32'h0);
    #2 resetn = 1'b0;
    #1;
    chk("t4_data_ok0", 32'(bus0.data_ok), 32'd0);
    chk("t4_addr_ok0", 32'(bus0.addr_ok), 32'd0);
    chk("t4_outst0", 32'(outst0), 32'd0);
    chk("t4_data_ok1", 32'(bus1.data_ok), 32'd0);
    chk("t4_outst1", 32'(outst1), 32'd0);
    q[0].delete(); q[1].delete();
    #1 resetn = 1'b1;
    idle(8);
    step(1'b1, 1'b0, 4'h0, 32'h1C00_0010, 32'h0);
    idle(3);
`ifndef DSRAM_RAND_DELAY_EN
    chk("t4_mem_kept", last_rdata[0], 32'h12AA_5678);
`endif
    drain();

    // Random mix over a 16-word window with random upper/alias bits
    for (int w = 0; w < 16; w++) begin
      step(1'b1, 1'b1, 4'hF, 32'h100 + 32'(w) * 4, $urandom());
      idle(1);
    end
    for (int n = 0; n < 1000; n++) begin
      a = ($urandom() & 32'hFFFF_C000) | ((32'h40 + $urandom_range(0, 15)) << 2)
          | $urandom_range(0, 3);
      step($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
           a, $urandom());
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
